// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the MEM-stage data memory access controller:
// FSM encoding, funct3 access codes, fault causes and access helpers.
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_BUS     = 2'b10;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b11;

    // Stores share the low encodings with loads; only loads may use the unsigned forms.
    function automatic logic access_legal(input logic is_load, input logic [2:0] f3,
                                          input logic [1:0] addr_lo);
        logic ok;
        case (f3)
            F3_LB:   ok = 1'b1;
            F3_LH:   ok = ~addr_lo[0];
            F3_LW:   ok = (addr_lo == 2'b00);
            F3_LBU:  ok = is_load;
            F3_LHU:  ok = is_load & ~addr_lo[0];
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [3:0] byte_enables(input logic [2:0] f3, input logic [1:0] addr_lo);
        logic [3:0] be;
        case (f3[1:0])
            2'b00:   be = 4'b0001 << addr_lo;
            2'b01:   be = 4'b0011 << addr_lo;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] lane_replicate(input logic [2:0] f3, input logic [31:0] data);
        logic [31:0] rep;
        case (f3[1:0])
            2'b00:   rep = {4{data[7:0]}};
            2'b01:   rep = {2{data[15:0]}};
            default: rep = data;
        endcase
        return rep;
    endfunction

endpackage

// File: rtl/mem_access_ctrl_load_align.sv
// Load lane selection and sign/zero extension of a captured read word.
module load_align
    import mem_ctrl_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_addr_lo,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_data
);

    logic [31:0] w_shifted;

    // Shift the addressed lane down to bit 0, then extend by access type.
    always_comb begin
        w_shifted = i_rdata >> {i_addr_lo, 3'b000};
        case (i_funct3)
            F3_LB:   o_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
            F3_LH:   o_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
            F3_LW:   o_data = w_shifted;
            F3_LBU:  o_data = {24'd0, w_shifted[7:0]};
            F3_LHU:  o_data = {16'd0, w_shifted[15:0]};
            default: o_data = 32'd0;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage data memory controller: checks, launches and times out one bus
// transfer per access while stalling the pipeline, then returns aligned load data.
module mem_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        MemRead_MEM,
    input  logic        MemWrite_MEM,
    input  logic [31:0] alu_MEM,
    input  logic [31:0] rs2_mem_data_MEM,
    input  logic [2:0]  funct3_MEM,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic        dmem_err,
    input  logic [31:0] dmem_rdata,
    output logic        mem_stall,
    output logic [31:0] load_data_MEM,
    output logic        fault_MEM,
    output logic [1:0]  fault_cause
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t            r_state;
    state_t            w_next_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [31:0]       r_addr;
    logic              r_we;
    logic [3:0]        r_be;
    logic [31:0]       r_wdata;
    logic [2:0]        r_funct3;
    logic              r_is_load;
    logic [31:0]       r_rdata;
    logic [1:0]        r_cause;

    logic              w_access;
    logic              w_legal;
    logic              w_start;
    logic              w_illegal;
    logic              w_timeout;
    logic              w_stall;
    logic              w_fault;
    logic [1:0]        w_cause;
    logic [31:0]       w_load;
    logic [31:0]       w_align_data;

    assign w_access  = MemRead_MEM | MemWrite_MEM;
    assign w_legal   = (MemRead_MEM ^ MemWrite_MEM) &
                       access_legal(MemRead_MEM, funct3_MEM, alu_MEM[1:0]);
    assign w_start   = w_access & w_legal;
    assign w_illegal = w_access & ~w_legal;
    assign w_timeout = (r_cnt == CNT_LAST);

    // State, latched request fields, timeout counter and captured response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_addr    <= 32'd0;
            r_we      <= 1'b0;
            r_be      <= 4'b0000;
            r_wdata   <= 32'd0;
            r_funct3  <= 3'b000;
            r_is_load <= 1'b0;
            r_rdata   <= 32'd0;
            r_cause   <= CAUSE_NONE;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                ST_IDLE: begin
                    r_cnt <= '0;
                    if (w_start) begin
                        r_addr    <= alu_MEM;
                        r_we      <= MemWrite_MEM;
                        r_be      <= byte_enables(funct3_MEM, alu_MEM[1:0]);
                        r_wdata   <= lane_replicate(funct3_MEM, rs2_mem_data_MEM);
                        r_funct3  <= funct3_MEM;
                        r_is_load <= MemRead_MEM;
                    end
                end
                ST_REQ: begin
                    if (dmem_ack) begin
                        r_rdata <= dmem_rdata;
                        r_cause <= dmem_err ? CAUSE_BUS : CAUSE_NONE;
                        r_cnt   <= '0;
                    end else if (w_timeout) begin
                        r_rdata <= 32'd0;
                        r_cause <= CAUSE_TIMEOUT;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                ST_DONE: begin
                    r_cause <= CAUSE_NONE;
                    r_cnt   <= '0;
                end
                default: begin
                    r_cnt <= '0;
                end
            endcase
        end
    end

    load_align u_load_align (
        .i_rdata   (r_rdata),
        .i_addr_lo (r_addr[1:0]),
        .i_funct3  (r_funct3),
        .o_data    (w_align_data)
    );

    // Next state plus stall/fault/load results; ack takes priority over timeout.
    always_comb begin
        w_next_state = r_state;
        w_stall      = 1'b0;
        w_fault      = 1'b0;
        w_cause      = CAUSE_NONE;
        w_load       = 32'd0;
        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    w_next_state = ST_REQ;
                    w_stall      = 1'b1;
                end else if (w_illegal) begin
                    w_fault = 1'b1;
                    w_cause = CAUSE_ILLEGAL;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_REQ: begin
                w_stall = 1'b1;
                if (dmem_ack || w_timeout) begin
                    w_next_state = ST_DONE;
                end else begin
                    w_next_state = ST_REQ;
                end
            end
            ST_DONE: begin
                w_next_state = ST_IDLE;
                w_fault      = (r_cause != CAUSE_NONE);
                w_cause      = r_cause;
                if (r_is_load && (r_cause == CAUSE_NONE)) begin
                    w_load = w_align_data;
                end else begin
                    w_load = 32'd0;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Combinational status is forced quiet while reset is held.
    assign mem_stall     = rst_n & w_stall;
    assign fault_MEM     = rst_n & w_fault;
    assign fault_cause   = rst_n ? w_cause : CAUSE_NONE;
    assign load_data_MEM = w_load;

    assign dmem_req   = (r_state == ST_REQ);
    assign dmem_we    = r_we;
    assign dmem_addr  = {r_addr[31:2], 2'b00};
    assign dmem_be    = r_be;
    assign dmem_wdata = r_wdata;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed vector table, timeout,
// late-ack and mid-transfer reset sequences, and randomized accesses vs a model.
module tb_mem_access_ctrl;

    logic        clk;
    logic        rst_n;
    logic        MemRead_MEM;
    logic        MemWrite_MEM;
    logic [31:0] alu_MEM;
    logic [31:0] rs2_mem_data_MEM;
    logic [2:0]  funct3_MEM;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic        dmem_err;
    logic [31:0] dmem_rdata;
    logic        mem_stall;
    logic [31:0] load_data_MEM;
    logic        fault_MEM;
    logic [1:0]  fault_cause;

    int total = 0;
    int bad   = 0;

    mem_access_ctrl #(.TIMEOUT_CYCLES(16)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .MemRead_MEM      (MemRead_MEM),
        .MemWrite_MEM     (MemWrite_MEM),
        .alu_MEM          (alu_MEM),
        .rs2_mem_data_MEM (rs2_mem_data_MEM),
        .funct3_MEM       (funct3_MEM),
        .dmem_req         (dmem_req),
        .dmem_we          (dmem_we),
        .dmem_addr        (dmem_addr),
        .dmem_be          (dmem_be),
        .dmem_wdata       (dmem_wdata),
        .dmem_ack         (dmem_ack),
        .dmem_err         (dmem_err),
        .dmem_rdata       (dmem_rdata),
        .mem_stall        (mem_stall),
        .load_data_MEM    (load_data_MEM),
        .fault_MEM        (fault_MEM),
        .fault_cause      (fault_cause)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        legal;
        int          stall;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        we;
        logic [31:0] addr;
        logic [31:0] load;
        logic [1:0]  cause;
    } exp_t;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] rdat;
        logic        err;
        int          ack_at;
        exp_t        e;
    } vec_t;

    typedef struct {
        int          stall;
        int          req_cycles;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] addr;
        logic [31:0] load;
        logic        we;
        logic        fault_idle;
        logic [1:0]  cause_idle;
        logic        req_idle;
        logic        fault_done;
        logic [1:0]  cause_done;
        logic        stall_done;
        logic        fault_after;
        logic        req_after;
        logic        unstable;
        logic        done;
    } obs_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: access rules written directly as arithmetic on sizes and offsets.
    function automatic exp_t model(input logic rd, input logic wr, input logic [2:0] f3,
                                   input logic [31:0] addr, input logic [31:0] wd,
                                   input logic [31:0] rdat, input logic err, input int ack_at);
        exp_t e;
        int nbytes, off;
        logic [31:0] mask, v;
        nbytes = 1 << f3[1:0];
        off    = int'(addr % 4);
        e.legal = (rd != wr) && (f3[1:0] != 2'b11) && (rd || f3[2] == 1'b0)
                  && (rd == 1'b0 || f3 != 3'b110) && (addr % nbytes == 0);
        e.stall = (ack_at == 0) ? 17 : 1 + ack_at;
        e.be    = 4'((((1 << nbytes) - 1) << off) & 15);
        case (nbytes)
            1:       e.wdata = {24'd0, wd[7:0]} * 32'h0101_0101;
            2:       e.wdata = {16'd0, wd[15:0]} * 32'h0001_0001;
            default: e.wdata = wd;
        endcase
        e.we   = wr;
        e.addr = addr - 32'(off);
        mask = (nbytes == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nbytes)) - 32'd1);
        v    = (rdat >> (8 * off)) & mask;
        if (f3[2] == 1'b0 && nbytes < 4 && v[8 * nbytes - 1]) v = v | ~mask;
        e.cause = (ack_at == 0) ? 2'b11 : (err ? 2'b10 : 2'b00);
        e.load  = (rd && e.cause == 2'b00) ? v : 32'd0;
        return e;
    endfunction

    task automatic run_txn(input logic rd, input logic wr, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wd,
                           input logic [31:0] rdat, input logic err, input int ack_at,
                           output obs_t o);
        bit fin;
        o = '{default: '0};
        fin = 1'b0;
        @(negedge clk);
        MemRead_MEM = rd; MemWrite_MEM = wr; funct3_MEM = f3;
        alu_MEM = addr; rs2_mem_data_MEM = wd;
        #1;
        o.stall      = int'(mem_stall);
        o.fault_idle = fault_MEM;
        o.cause_idle = fault_cause;
        o.req_idle   = dmem_req;
        if (!mem_stall) begin
            @(negedge clk);
            MemRead_MEM = 1'b0; MemWrite_MEM = 1'b0;
            #1;
            o.fault_after = fault_MEM;
            o.req_after   = dmem_req;
            return;
        end
        for (int cyc = 0; cyc < 40 && !fin; cyc++) begin
            @(negedge clk);
            alu_MEM = $urandom; rs2_mem_data_MEM = $urandom;
            #1;
            if (dmem_req) begin
                o.req_cycles++;
                o.stall += int'(mem_stall);
                if (o.req_cycles == 1) begin
                    o.be = dmem_be; o.wdata = dmem_wdata; o.addr = dmem_addr; o.we = dmem_we;
                end else if (o.be !== dmem_be || o.wdata !== dmem_wdata ||
                             o.addr !== dmem_addr || o.we !== dmem_we) begin
                    o.unstable = 1'b1;
                end
                if (o.req_cycles == ack_at) begin
                    dmem_ack = 1'b1; dmem_rdata = rdat; dmem_err = err;
                end
            end else begin
                fin = 1'b1;
                o.stall_done = mem_stall;
                o.load       = load_data_MEM;
                o.fault_done = fault_MEM;
                o.cause_done = fault_cause;
                dmem_ack = 1'b0; dmem_err = 1'b0; dmem_rdata = $urandom;
                MemRead_MEM = 1'b0; MemWrite_MEM = 1'b0;
            end
        end
        o.done = fin;
        @(negedge clk);
        #1;
        o.fault_after = fault_MEM;
        o.req_after   = dmem_req;
    endtask

    task automatic check_txn(input string tag, input exp_t e, input obs_t o);
        if (!e.legal) begin
            chk({tag, "_fault"}, 32'(o.fault_idle), 32'd1);
            chk({tag, "_cause"}, 32'(o.cause_idle), 32'd1);
            chk({tag, "_stall"}, 32'(o.stall), 32'd0);
            chk({tag, "_noreq"}, 32'(o.req_idle | o.req_after), 32'd0);
            chk({tag, "_pulse"}, 32'(o.fault_after), 32'd0);
        end else begin
            chk({tag, "_done"},  32'(o.done), 32'd1);
            chk({tag, "_ifault"}, 32'(o.fault_idle), 32'd0);
            chk({tag, "_stall"}, 32'(o.stall), 32'(e.stall));
            chk({tag, "_reqcyc"}, 32'(o.req_cycles), 32'(e.stall - 1));
            chk({tag, "_be"},    32'(o.be), 32'(e.be));
            chk({tag, "_wdata"}, o.wdata, e.wdata);
            chk({tag, "_we"},    32'(o.we), 32'(e.we));
            chk({tag, "_addr"},  o.addr, e.addr);
            chk({tag, "_stable"}, 32'(o.unstable), 32'd0);
            chk({tag, "_load"},  o.load, e.load);
            chk({tag, "_dstall"}, 32'(o.stall_done), 32'd0);
            chk({tag, "_dfault"}, 32'(o.fault_done), 32'(e.cause != 2'b00));
            chk({tag, "_dcause"}, 32'(o.cause_done), 32'(e.cause));
            chk({tag, "_pulse"}, 32'(o.fault_after | o.req_after), 32'd0);
        end
    endtask

    vec_t vecs[15];

    initial begin
        obs_t o;
        exp_t e;
        logic rd, wr;
        int sel;

        //          rd    wr    f3      addr          wd            rdat          err  ack  legal stall be       wdata         we    addr          load          cause
        vecs[0]  = '{1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 1'b0, 2, '{1'b1, 3, 4'b1111, 32'h0, 1'b0, 32'h0000_0100, 32'hDEAD_BEEF, 2'b00}};
        vecs[1]  = '{1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0, 32'h80FF_FFFF, 1'b0, 1, '{1'b1, 2, 4'b1000, 32'h0, 1'b0, 32'h0000_0100, 32'hFFFF_FF80, 2'b00}};
        vecs[2]  = '{1'b1, 1'b0, 3'b100, 32'h0000_0103, 32'h0, 32'h80FF_FFFF, 1'b0, 1, '{1'b1, 2, 4'b1000, 32'h0, 1'b0, 32'h0000_0100, 32'h0000_0080, 2'b00}};
        vecs[3]  = '{1'b0, 1'b1, 3'b001, 32'h0000_0202, 32'h1234_ABCD, 32'h0, 1'b0, 1, '{1'b1, 2, 4'b1100, 32'hABCD_ABCD, 1'b1, 32'h0000_0200, 32'h0, 2'b00}};
        vecs[4]  = '{1'b1, 1'b0, 3'b010, 32'h0000_0101, 32'h0, 32'h0, 1'b0, 1, '{1'b0, 0, 4'b0000, 32'h0, 1'b0, 32'h0, 32'h0, 2'b01}};
        vecs[5]  = '{1'b1, 1'b0, 3'b001, 32'h0000_0102, 32'h0, 32'h8001_7FFF, 1'b0, 3, '{1'b1, 4, 4'b1100, 32'h0, 1'b0, 32'h0000_0100, 32'hFFFF_8001, 2'b00}};
        vecs[6]  = '{1'b1, 1'b0, 3'b101, 32'h0000_0100, 32'h0, 32'h1234_F00D, 1'b0, 1, '{1'b1, 2, 4'b0011, 32'h0, 1'b0, 32'h0000_0100, 32'h0000_F00D, 2'b00}};
        vecs[7]  = '{1'b0, 1'b1, 3'b010, 32'h0000_0300, 32'hCAFE_F00D, 32'h0, 1'b1, 1, '{1'b1, 2, 4'b1111, 32'hCAFE_F00D, 1'b1, 32'h0000_0300, 32'h0, 2'b10}};
        vecs[8]  = '{1'b1, 1'b0, 3'b011, 32'h0000_0000, 32'h0, 32'h0, 1'b0, 1, '{1'b0, 0, 4'b0000, 32'h0, 1'b0, 32'h0, 32'h0, 2'b01}};
        vecs[9]  = '{1'b0, 1'b1, 3'b100, 32'h0000_0000, 32'h0, 32'h0, 1'b0, 1, '{1'b0, 0, 4'b0000, 32'h0, 1'b0, 32'h0, 32'h0, 2'b01}};
        vecs[10] = '{1'b1, 1'b1, 3'b010, 32'h0000_0000, 32'h0, 32'h0, 1'b0, 1, '{1'b0, 0, 4'b0000, 32'h0, 1'b0, 32'h0, 32'h0, 2'b01}};
        vecs[11] = '{1'b0, 1'b1, 3'b001, 32'h0000_0201, 32'h0, 32'h0, 1'b0, 1, '{1'b0, 0, 4'b0000, 32'h0, 1'b0, 32'h0, 32'h0, 2'b01}};
        vecs[12] = '{1'b0, 1'b1, 3'b000, 32'h0000_0101, 32'h0000_00A5, 32'h0, 1'b0, 2, '{1'b1, 3, 4'b0010, 32'hA5A5_A5A5, 1'b1, 32'h0000_0100, 32'h0, 2'b00}};
        vecs[13] = '{1'b1, 1'b0, 3'b010, 32'h0000_0040, 32'h0, 32'h1234_5678, 1'b1, 1, '{1'b1, 2, 4'b1111, 32'h0, 1'b0, 32'h0000_0040, 32'h0, 2'b10}};
        vecs[14] = '{1'b0, 1'b1, 3'b010, 32'h0000_0500, 32'h1122_3344, 32'h0, 1'b0, 0, '{1'b1, 17, 4'b1111, 32'h1122_3344, 1'b1, 32'h0000_0500, 32'h0, 2'b11}};

        rst_n = 1'b0;
        MemRead_MEM = 1'b1; MemWrite_MEM = 1'b0; funct3_MEM = 3'b010;
        alu_MEM = 32'h0000_0100; rs2_mem_data_MEM = 32'h0;
        dmem_ack = 1'b0; dmem_err = 1'b0; dmem_rdata = 32'h0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_req",   32'(dmem_req), 32'd0);
        chk("rst_we",    32'(dmem_we), 32'd0);
        chk("rst_be",    32'(dmem_be), 32'd0);
        chk("rst_addr",  dmem_addr, 32'd0);
        chk("rst_wdata", dmem_wdata, 32'd0);
        chk("rst_stall", 32'(mem_stall), 32'd0);
        chk("rst_fault", 32'(fault_MEM), 32'd0);
        chk("rst_cause", 32'(fault_cause), 32'd0);
        MemRead_MEM = 1'b0;
        rst_n = 1'b1;

        for (int i = 0; i < 15; i++) begin
            run_txn(vecs[i].rd, vecs[i].wr, vecs[i].f3, vecs[i].addr, vecs[i].wd,
                    vecs[i].rdat, vecs[i].err, vecs[i].ack_at, o);
            check_txn($sformatf("vec%0d", i), vecs[i].e, o);
        end

        // Ack arriving while idle must not start or finish anything.
        @(negedge clk);
        dmem_ack = 1'b1; dmem_rdata = 32'h5555_AAAA;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            chk($sformatf("late_ack_req%0d", i), 32'(dmem_req), 32'd0);
            chk($sformatf("late_ack_flt%0d", i), 32'({mem_stall, fault_MEM}), 32'd0);
        end
        dmem_ack = 1'b0;

        // Reset in the middle of a transfer abandons it immediately.
        @(negedge clk);
        MemRead_MEM = 1'b1; funct3_MEM = 3'b010; alu_MEM = 32'h0000_0400;
        repeat (2) @(negedge clk);
        #1;
        chk("mid_req_up", 32'(dmem_req), 32'd1);
        #1;
        rst_n = 1'b0;
        MemRead_MEM = 1'b0;
        #1;
        chk("mid_rst_req",   32'(dmem_req), 32'd0);
        chk("mid_rst_stall", 32'(mem_stall), 32'd0);
        chk("mid_rst_be",    32'(dmem_be), 32'd0);
        chk("mid_rst_addr",  dmem_addr, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            chk($sformatf("post_rst_flt%0d", i), 32'(fault_MEM), 32'd0);
            chk($sformatf("post_rst_req%0d", i), 32'(dmem_req), 32'd0);
        end

        for (int n = 0; n < 60; n++) begin
            logic [2:0]  f3;
            logic [31:0] addr, wd, rdat;
            logic        err;
            int          ack_at;
            sel = $urandom_range(0, 9);
            rd = (sel <= 5); wr = (sel == 0) || (sel >= 6);
            f3 = 3'($urandom_range(0, 7));
            addr = $urandom; wd = $urandom; rdat = $urandom;
            if ($urandom_range(0, 2) != 0) addr[1:0] = 2'b00;
            err = ($urandom_range(0, 7) == 0);
            ack_at = $urandom_range(1, 4);
            e = model(rd, wr, f3, addr, wd, rdat, err, ack_at);
            run_txn(rd, wr, f3, addr, wd, rdat, err, ack_at, o);
            check_txn($sformatf("rnd%0d", n), e, o);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
